// File: rtl/z80_io_pkg.sv
// Shared definitions for the Z80 I/O responder: FSM encodings, register offsets,
// CTRL bit positions and reset values.
package z80_io_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_INTA = 2'd3;

    localparam logic [1:0] OFS_DATA0  = 2'd0;
    localparam logic [1:0] OFS_DATA1  = 2'd1;
    localparam logic [1:0] OFS_VECTOR = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    localparam int CTRL_PEND = 0;
    localparam int CTRL_IEN  = 1;

    localparam logic [7:0] DATA_RST   = 8'h00;
    localparam logic [7:0] VECTOR_RST = 8'hFF;
    localparam logic [7:0] UNIMPL_RD  = 8'hFF;

    // The low two address bits pick the register, so they never take part in the match.
    function automatic logic addr_match(input logic [7:0] addr, input logic [7:0] base);
        return addr[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/z80_io_waitgen.sv
// Wait-state generator: a 3-bit loadable down-counter that holds nWAIT low for
// WAIT_STATES clocks after start and flags done on the final one.
module z80_io_waitgen #(
    parameter int WAIT_STATES = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    output logic nwait_o,
    output logic done_o
);

    localparam logic [2:0] LOAD_VAL = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i && (WAIT_STATES > 0)) begin
            busy_d = 1'b1;
            cnt_d  = LOAD_VAL;
        end else if (busy_q) begin
            if (cnt_q == 3'd0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign nwait_o = ~busy_q;
    assign done_o  = busy_q && (cnt_q == 3'd0);

endmodule

// File: rtl/z80_io_responder.sv
// Z80 IORQ target: 4-port register window with wait states and IM2 interrupt.
// Interrupt support (PEND/IEN/VECTOR, acknowledge cycle, nINT) is built only with Z80_IO_IRQ_EN.
//
// state | meaning
// IDLE  | bus idle, waiting for a decoded I/O cycle or an interrupt acknowledge
// WAIT  | access accepted, nWAIT held low by the wait generator
// DONE  | access complete (write committed on entry), waiting for nIORQ to rise
// INTA  | interrupt acknowledge, VECTOR driven while nIORQ is low
module z80_io_responder
    import z80_io_pkg::*;
#(
    parameter logic [7:0] BASE        = 8'h40,
    parameter int         WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    inout  wire  [7:0]  D,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic        nWAIT,
    output logic        nINT,
    input  logic        irq_set,
    output logic [7:0]  data0_q
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);

    state_t     state_q, state_d;
    logic [1:0] ofs_q, ofs_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_drv_q, rd_drv_d;
    logic [7:0] data0_d;
    logic [7:0] data1_q, data1_d;

    logic       io_req, inta_req, req_wr;
    logic       wg_start, wg_done, wg_nwait;
    logic       commit, inta_done;
    logic [1:0] commit_ofs;
    logic [7:0] reg_rd, ctrl_rd, drive_val;
    logic       drive_en;

`ifdef Z80_IO_IRQ_EN
    logic [7:0] vector_q, vector_d;
    logic       pend_q, pend_d;
    logic       ien_q, ien_d;
    logic       pend_clr;
    logic       nint_q, nint_d;
    logic       unused_sig;
    assign unused_sig = ^A[15:8];
`else
    logic       unused_sig;
    assign unused_sig = ^{A[15:8], irq_set, inta_done, ofs_q};
`endif

    assign io_req = ~nIORQ & nM1 & (~nRD | ~nWR) & addr_match(A[7:0], BASE);
    assign req_wr = nRD & ~nWR;

`ifdef Z80_IO_IRQ_EN
    assign inta_req = ~nIORQ & ~nM1 & ~nint_q;
`else
    assign inta_req = 1'b0;
`endif

    always_comb begin
        ctrl_rd = 8'h00;
`ifdef Z80_IO_IRQ_EN
        ctrl_rd[CTRL_PEND] = pend_q;
        ctrl_rd[CTRL_IEN]  = ien_q;
`endif
        case (A[1:0])
            OFS_DATA0:  reg_rd = data0_q;
            OFS_DATA1:  reg_rd = data1_q;
`ifdef Z80_IO_IRQ_EN
            OFS_VECTOR: reg_rd = vector_q;
            OFS_CTRL:   reg_rd = ctrl_rd;
`endif
            default:    reg_rd = UNIMPL_RD;
        endcase
    end

    z80_io_waitgen #(
        .WAIT_STATES(WAIT_STATES)
    ) u_waitgen (
        .clk_i   (CLK),
        .rst_n_i (nRESET),
        .start_i (wg_start),
        .nwait_o (wg_nwait),
        .done_o  (wg_done)
    );

    always_comb begin
        state_d    = state_q;
        ofs_d      = ofs_q;
        is_wr_d    = is_wr_q;
        rd_data_d  = rd_data_q;
        rd_drv_d   = rd_drv_q;
        wg_start   = 1'b0;
        commit     = 1'b0;
        commit_ofs = ofs_q;
        inta_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_req) begin
                    ofs_d     = A[1:0];
                    is_wr_d   = req_wr;
                    rd_data_d = reg_rd;
                    rd_drv_d  = ~req_wr;
                    if (NO_WAIT) begin
                        // Zero wait states: the write lands on the decode edge itself.
                        state_d    = ST_DONE;
                        commit     = req_wr;
                        commit_ofs = A[1:0];
                    end else begin
                        state_d  = ST_WAIT;
                        wg_start = 1'b1;
                    end
                end else if (inta_req) begin
                    state_d = ST_INTA;
                end
            end
            ST_WAIT: begin
                if (wg_done) begin
                    state_d = ST_DONE;
                    commit  = is_wr_q;
                end
            end
            ST_DONE: begin
                if (nIORQ) begin
                    state_d  = ST_IDLE;
                    rd_drv_d = 1'b0;
                end
            end
            ST_INTA: begin
                if (nIORQ) begin
                    state_d   = ST_IDLE;
                    inta_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
`ifdef Z80_IO_IRQ_EN
        vector_d = vector_q;
        ien_d    = ien_q;
        pend_clr = 1'b0;
`endif
        if (commit) begin
            case (commit_ofs)
                OFS_DATA0:  data0_d = D;
                OFS_DATA1:  data1_d = D;
`ifdef Z80_IO_IRQ_EN
                OFS_VECTOR: vector_d = D;
                OFS_CTRL: begin
                    ien_d    = D[CTRL_IEN];
                    pend_clr = D[CTRL_PEND];
                end
`endif
                default: ;
            endcase
        end
`ifdef Z80_IO_IRQ_EN
        // A new request beats any clear arriving on the same edge.
        pend_d = irq_set | (pend_q & ~pend_clr & ~inta_done);
        nint_d = ~(pend_d & ien_d);
`endif
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            ofs_q     <= OFS_DATA0;
            is_wr_q   <= 1'b0;
            rd_data_q <= 8'h00;
            rd_drv_q  <= 1'b0;
            data0_q   <= DATA_RST;
            data1_q   <= DATA_RST;
`ifdef Z80_IO_IRQ_EN
            vector_q  <= VECTOR_RST;
            pend_q    <= 1'b0;
            ien_q     <= 1'b0;
            nint_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            ofs_q     <= ofs_d;
            is_wr_q   <= is_wr_d;
            rd_data_q <= rd_data_d;
            rd_drv_q  <= rd_drv_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
`ifdef Z80_IO_IRQ_EN
            vector_q  <= vector_d;
            pend_q    <= pend_d;
            ien_q     <= ien_d;
            nint_q    <= nint_d;
`endif
        end
    end

    // Read drive releases combinationally as soon as the CPU lifts nIORQ or nRD.
    always_comb begin
        drive_en  = rd_drv_q & ~nIORQ & ~nRD;
        drive_val = rd_data_q;
`ifdef Z80_IO_IRQ_EN
        if ((state_q == ST_INTA) && !nIORQ) begin
            drive_en  = 1'b1;
            drive_val = vector_q;
        end
`endif
    end

    assign D     = drive_en ? drive_val : 8'hzz;
    assign nWAIT = wg_nwait;
`ifdef Z80_IO_IRQ_EN
    assign nINT  = nint_q;
`else
    assign nINT  = 1'b1;
`endif

endmodule

// File: doc/z80_io_responder.md
# z80_io_responder

Synchronous Z80 I/O-space responder: the target side of the CPU's IORQ read/write and interrupt-acknowledge cycles. It decodes a 4-port window, inserts a programmable number of wait states via nWAIT, services reads and writes to a small register file, and raises nINT with an IM2 vector supplied during acknowledge. It sits on the same bus interface as the RAM and I/O models in the top-level bench and serves as a reusable peripheral for system tests.

## Interface
- BASE, 8'h40: port base; A[7:2] == BASE[7:2] selects; BASE[1:0] ignored.
- WAIT_STATES, 1: nWAIT low clocks per access, range 0..7.
- CLK  in  1  bus clock; all logic on posedge.
- nRESET  in  1  reset, synchronous, active-low.
- A  in  16  address; only A[7:0] decoded.
- D  inout  8  data bus; driven only as specified below, else 'z.
- nIORQ, nRD, nWR, nM1  in  1 each  Z80 bus controls, active-low.
- nWAIT  out  1  wait request, active-low.
- nINT  out  1  interrupt request, active-low, level.
- irq_set  in  1  local one-clock pulse; sets pending.
- data0_q  out  8  current DATA0 register value.

## Operation
- Registers, offset A[1:0]: 0 DATA0 r/w, reset 8'h00; 1 DATA1 r/w, reset 8'h00; 2 VECTOR r/w, reset 8'hFF; 3 CTRL: bit0 PEND (read; write 1 clears), bit1 IEN r/w (reset 0), bits[7:2] read 0.
- FSM states IDLE, WAIT, DONE, INTA.
- IDLE -> WAIT: nIORQ=0, nM1=1, (nRD=0 or nWR=0), address match, WAIT_STATES>0. Goes straight to DONE if WAIT_STATES=0. Latch offset, direction, read data on this edge.
- WAIT: nWAIT=0; counter loads WAIT_STATES-1, decrements per clock; at 0 -> DONE.
- DONE: write committed exactly once on entry edge, using D sampled that edge; stay until nIORQ=1 -> IDLE.
- Read: D driven with latched data from IDLE exit until nIORQ or nRD deasserts (combinational release).
- IDLE -> INTA: nIORQ=0 and nM1=0 while nINT=0; drive D=VECTOR, no waits; on nIORQ=1 clear PEND -> IDLE. No pending → INTA ignored, D stays 'z.
- nINT = ~(PEND & IEN), registered.
- irq_set and CTRL write-1-clear same clock: set wins.
- Non-matching address, or nRD and nWR both high: stay IDLE, no drive.

## Timing
- Reset values: nWAIT=1, nINT=1, D='z, data0_q=8'h00, state IDLE, PEND=0.
- nWAIT falls the clock after decode; held exactly WAIT_STATES clocks.
- Write visible on data0_q 1 clock after DONE entry.
- nINT asserts 1 clock after irq_set with IEN=1; deasserts 1 clock after INTA completes.
- nRESET low mid-access: next edge forces IDLE, nWAIT=1, D released, all registers to reset values; in-flight write discarded.

## Configuration
- Z80_IO_IRQ_EN defined: PEND, IEN, VECTOR, INTA state, nINT as above.
- Undefined: nINT tied 1, irq_set ignored, INTA never entered, offsets 2/3 read 8'hFF and ignore writes.

## Structure
- Shared package z80_io_pkg: state enum, offset constants (OFS_DATA0..OFS_CTRL), CTRL bit indices, VECTOR reset value.
- One sub-module z80_io_waitgen: 3-bit loadable down-counter producing nWAIT and done.

## Test plan
- Reset: hold nRESET low 3 clocks -> nWAIT=1, nINT=1, D='z, DATA0 reads 8'h00.
- OUT (0x40),8'hA5 with WAIT_STATES=2 -> nWAIT low exactly 2 clocks, data0_q=8'hA5; IN (0x40) returns 8'hA5.
- IN (0x44) (non-matching) -> D stays 'z, nWAIT stays 1.
- Write 8'h02 to 0x43, pulse irq_set -> nINT=0; INTA cycle -> D=8'hFF; after cycle nINT=1, CTRL reads 8'h02.
- Write VECTOR=8'h3C, irq_set and write 8'h03 to CTRL same clock -> PEND stays 1, INTA returns 8'h3C.
- nRESET low during WAIT of OUT (0x41),8'h77 -> nWAIT=1 next clock, DATA1 reads 8'h00.
